// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory for the
// current PC over a req/gnt/rvalid handshake, buffers returned words in a
// small FIFO, and presents them to decode with a valid/ready handshake.
// Supports flush on branch/jump redirect.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc_in               current PC from the PC register
//   pc_advance          PC load enable, one pulse per granted fetch
//   flush               redirect: drop buffered and in-flight instructions
//   imem_req/addr       read request and word-aligned address
//   imem_gnt            memory accepted the request
//   imem_rvalid/rdata   read response
//   instr_valid/instr/instr_pc  buffer head presented to decode
//   instr_ready         decode consumes the head this cycle
module instr_fetch_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]        state_q,   state_d;
  logic              discard_q, discard_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

  logic [DATA_W-1:0] buf_instr_q [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc_q    [BUF_DEPTH];

  logic req_c;
  logic grant_c;
  logic push_c;
  logic pop_c;

  // Request/handshake qualifiers; space is reserved at issue so push never overflows
  always_comb begin
    req_c   = ~rst & (state_q == ST_IDLE) & (count_q < CNT_W'(BUF_DEPTH)) & ~flush;
    grant_c = req_c & imem_gnt;
    push_c  = (state_q == ST_RESP) & imem_rvalid & ~flush & ~discard_q;
    pop_c   = (count_q != '0) & instr_ready & ~flush;
  end

  assign imem_req    = req_c;
  assign pc_advance  = grant_c;
  assign imem_addr   = req_c ? {pc_in[ADDR_W-1:2], 2'b00} : '0;
  assign instr_valid = (count_q != '0);
  assign instr       = buf_instr_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];

  // Next-state: FSM, discard flag, FIFO bookkeeping
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pend_pc_d = pend_pc_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          pend_pc_d = pc_in;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        // Any response closes the transaction; it is dropped if flushed or stale
        if (imem_rvalid) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      // Pointers wrap naturally because BUF_DEPTH is a power of two
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      discard_q <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Instruction buffer storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else if (push_c) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= pend_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_chk;
  int n_fail;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; idle_inputs(); pc_in = 32'h0000_0044; imem_rdata = '0;
    tick(); tick();
    imem_gnt = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
    n_chk++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL reset_pc_advance got=%0h exp=0", pc_advance); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0h exp=0", instr_valid); end
    n_chk++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%0h exp=0", instr); end
    n_chk++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc got=%0h exp=0", instr_pc); end
    imem_gnt = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    pc_in = 32'h0; imem_gnt = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req got=%0h exp=1", imem_req); end
    n_chk++; if (pc_advance !== 1'b1) begin n_fail++; $display("FAIL basic_pc_advance got=%0h exp=1", pc_advance); end
    n_chk++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr got=%0h exp=0", imem_addr); end
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_resp got=%0h exp=0", imem_req); end
    n_chk++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL basic_adv_resp got=%0h exp=0", pc_advance); end
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early got=%0h exp=0", instr_valid); end
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_chk++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%0h exp=1", instr_valid); end
    n_chk++; if (instr !== 32'h13) begin n_fail++; $display("FAIL basic_instr got=%0h exp=13", instr); end
    n_chk++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL basic_instr_pc got=%0h exp=0", instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    #1;
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop got=%0h exp=0", instr_valid); end
  endtask

  task automatic test_full;
    logic [31:0] d [3];
    d[0] = 32'hA000_0000; d[1] = 32'hA000_0001; d[2] = 32'hA000_0002;
    for (int i = 0; i < 2; i++) begin
      pc_in = 32'(i * 4); imem_gnt = 1'b1;
      #1;
      n_chk++; if (pc_advance !== 1'b1) begin n_fail++; $display("FAIL full_fill_adv%0d got=%0h exp=1", i, pc_advance); end
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = d[i];
      tick();
      imem_rvalid = 1'b0;
    end
    pc_in = 32'h8; imem_gnt = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req got=%0h exp=0", imem_req); end
    n_chk++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL full_adv got=%0h exp=0", pc_advance); end
    n_chk++; if (instr !== d[0]) begin n_fail++; $display("FAIL full_head got=%0h exp=%0h", instr, d[0]); end
    n_chk++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL full_head_pc got=%0h exp=0", instr_pc); end
    tick();
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req_hold got=%0h exp=0", imem_req); end
    instr_ready = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req_pop_cycle got=%0h exp=0", imem_req); end
    tick();
    instr_ready = 1'b0;
    #1;
    n_chk++; if (instr !== d[1]) begin n_fail++; $display("FAIL full_head2 got=%0h exp=%0h", instr, d[1]); end
    n_chk++; if (instr_pc !== 32'h4) begin n_fail++; $display("FAIL full_head2_pc got=%0h exp=4", instr_pc); end
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL full_req_after_pop got=%0h exp=1", imem_req); end
    n_chk++; if (pc_advance !== 1'b1) begin n_fail++; $display("FAIL full_adv_after_pop got=%0h exp=1", pc_advance); end
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = d[2];
    tick();
    imem_rvalid = 1'b0; instr_ready = 1'b1;
    #1;
    n_chk++; if (instr !== d[1]) begin n_fail++; $display("FAIL full_drain0 got=%0h exp=%0h", instr, d[1]); end
    tick();
    n_chk++; if (instr !== d[2]) begin n_fail++; $display("FAIL full_wrap_instr got=%0h exp=%0h", instr, d[2]); end
    n_chk++; if (instr_pc !== 32'h8) begin n_fail++; $display("FAIL full_wrap_pc got=%0h exp=8", instr_pc); end
    tick();
    instr_ready = 1'b0;
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%0h exp=0", instr_valid); end
  endtask

  task automatic test_stall;
    pc_in = 32'h10; imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_req%0d got=%0h exp=1", i, imem_req); end
      n_chk++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL stall_addr%0d got=%0h exp=10", i, imem_addr); end
      n_chk++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL stall_adv%0d got=%0h exp=0", i, pc_advance); end
      tick();
    end
    imem_gnt = 1'b1;
    #1;
    n_chk++; if (pc_advance !== 1'b1) begin n_fail++; $display("FAIL stall_grant got=%0h exp=1", pc_advance); end
    tick();
    imem_gnt = 1'b1;
    #1;
    n_chk++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL stall_single_pulse got=%0h exp=0", pc_advance); end
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_10AB;
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_chk++; if (instr_pc !== 32'h10) begin n_fail++; $display("FAIL stall_instr_pc got=%0h exp=10", instr_pc); end
    n_chk++; if (instr !== 32'h10AB) begin n_fail++; $display("FAIL stall_instr got=%0h exp=10ab", instr); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_flush_resp;
    pc_in = 32'h40; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b1; flush = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flresp_req got=%0h exp=0", imem_req); end
    n_chk++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL flresp_adv got=%0h exp=0", pc_advance); end
    tick();
    flush = 1'b0; imem_gnt = 1'b0; pc_in = 32'h100;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flresp_wait_req got=%0h exp=0", imem_req); end
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flresp_dropped got=%0h exp=0", instr_valid); end
    n_chk++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL flresp_redirect_addr got=%0h exp=100", imem_addr); end
    imem_gnt = 1'b1;
    #1;
    n_chk++; if (pc_advance !== 1'b1) begin n_fail++; $display("FAIL flresp_redirect_adv got=%0h exp=1", pc_advance); end
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_1234;
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_chk++; if (instr !== 32'h1234) begin n_fail++; $display("FAIL flresp_new_instr got=%0h exp=1234", instr); end
    n_chk++; if (instr_pc !== 32'h100) begin n_fail++; $display("FAIL flresp_new_pc got=%0h exp=100", instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_flush_rvalid;
    pc_in = 32'h300; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h300;
    tick();
    imem_rvalid = 1'b0; pc_in = 32'h304; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00BA_DBAD; flush = 1'b1; instr_ready = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flrv_req got=%0h exp=0", imem_req); end
    tick();
    imem_rvalid = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    #1;
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flrv_empty got=%0h exp=0", instr_valid); end
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL flrv_idle_req got=%0h exp=1", imem_req); end
    for (int i = 0; i < 2; i++) begin
      pc_in = 32'(32'h310 + 32'(i * 4)); imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = pc_in;
      tick();
      imem_rvalid = 1'b0;
    end
    #1;
    n_chk++; if (instr !== 32'h310) begin n_fail++; $display("FAIL flrv_full_head got=%0h exp=310", instr); end
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flrv_full_req got=%0h exp=0", imem_req); end
    flush = 1'b1; instr_ready = 1'b1;
    tick();
    flush = 1'b0; instr_ready = 1'b0;
    #1;
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flrv_full_flushed got=%0h exp=0", instr_valid); end
    pc_in = 32'h320; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0320;
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_chk++; if (instr !== 32'h320) begin n_fail++; $display("FAIL flrv_refetch got=%0h exp=320", instr); end
    n_chk++; if (instr_pc !== 32'h320) begin n_fail++; $display("FAIL flrv_refetch_pc got=%0h exp=320", instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d;
    logic [31:0] exp_pc;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_in = 32'(32'h200 + 32'(i * 4)); imem_gnt = 1'b1;
      if (i == 2) pc_in = 32'h206;
      #1;
      n_chk++; if (pc_advance !== 1'b1) begin n_fail++; $display("FAIL b2b_adv%0d got=%0h exp=1", i, pc_advance); end
      n_chk++; if (imem_addr !== (pc_in & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL b2b_addr%0d got=%0h exp=%0h", i, imem_addr, pc_in & 32'hFFFF_FFFC); end
      if (i > 0) begin
        n_chk++; if (instr !== exp_d) begin n_fail++; $display("FAIL b2b_instr%0d got=%0h exp=%0h", i, instr, exp_d); end
        n_chk++; if (instr_pc !== exp_pc) begin n_fail++; $display("FAIL b2b_pc%0d got=%0h exp=%0h", i, instr_pc, exp_pc); end
      end
      exp_pc = pc_in;
      exp_d  = 32'(32'hA100_0000 + 32'(i));
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = exp_d;
      #1;
      n_chk++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL b2b_gap%0d got=%0h exp=0", i, pc_advance); end
      tick();
      imem_rvalid = 1'b0;
    end
    #1;
    n_chk++; if (instr !== 32'hA100_0003) begin n_fail++; $display("FAIL b2b_last got=%0h exp=a1000003", instr); end
    tick();
    instr_ready = 1'b0;
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got=%0h exp=0", instr_valid); end
  endtask

  task automatic test_reset_mid;
    pc_in = 32'h20; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; rst = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req got=%0h exp=0", imem_req); end
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%0h exp=0", instr_valid); end
    tick();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
    #1;
    n_chk++; if (pc_advance !== 1'b0) begin n_fail++; $display("FAIL rmid_adv got=%0h exp=0", pc_advance); end
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_chk++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stray got=%0h exp=0", instr_valid); end
    n_chk++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rmid_instr got=%0h exp=0", instr); end
    n_chk++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rmid_instr_pc got=%0h exp=0", instr_pc); end
    imem_gnt = 1'b1;
    #1;
    n_chk++; if (pc_advance !== 1'b1) begin n_fail++; $display("FAIL rmid_new_grant got=%0h exp=1", pc_advance); end
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_5555;
    tick();
    imem_rvalid = 1'b0;
    #1;
    n_chk++; if (instr !== 32'h5555) begin n_fail++; $display("FAIL rmid_instr_new got=%0h exp=5555", instr); end
    n_chk++; if (instr_pc !== 32'h20) begin n_fail++; $display("FAIL rmid_pc_new got=%0h exp=20", instr_pc); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    test_reset();
    test_basic();
    test_full();
    test_stall();
    test_flush_resp();
    test_flush_rvalid();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the program counter register in the single-cycle processor datapath. It takes the current PC and issues word reads to instruction memory over a req/gnt/rvalid handshake. Returned words go into a small instruction buffer, which is presented to decode with a valid/ready handshake. It drives pc_advance, the load enable that lets the PC register take next_pc. It also supports flush on taken branch or jump redirect.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
DATA_W, 32, instruction word width
BUF_DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
pc_in  input  ADDR_W  current PC value from the PC register
pc_advance  output  1  PC load enable; high for exactly one cycle per accepted fetch
flush  input  1  redirect; discard buffered and in-flight instructions
imem_req  output  1  read request to instruction memory
imem_addr  output  ADDR_W  word-aligned read address
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  DATA_W  read data
instr_valid  output  1  buffer head holds a valid instruction
instr  output  DATA_W  instruction at buffer head
instr_pc  output  ADDR_W  PC of instruction at buffer head
instr_ready  input  1  decode consumes head this cycle

Behaviour:
- Reset (async):
  - State goes to IDLE; buffer count 0; read/write pointers 0; discard flag 0.
  - All outputs are 0: pc_advance, imem_req, imem_addr, instr_valid, instr, instr_pc.
- imem_addr = {pc_in[ADDR_W-1:2], 2'b00} whenever imem_req=1; otherwise 0. instr_pc keeps the unmasked pc_in captured at grant.
- States:
  - IDLE: no transaction outstanding.
  - RESP: request granted, awaiting rvalid.
  - At most one outstanding request at a time.
- Request issue (combinational): imem_req = (state==IDLE) & (count < BUF_DEPTH) & ~flush.
  - count is the registered value; a same-cycle pop does not create space.
- Grant:
  - pc_advance = imem_req & imem_gnt.
  - On grant: capture pc_in as the pending PC; IDLE->RESP.
  - Without grant: stay IDLE and re-request next cycle. The PC does not move, so the address is unchanged.
  - imem_req may be withdrawn only because of flush or full; the memory tolerates withdrawal.
- RESP, normal:
  - On imem_rvalid: push {pending PC, imem_rdata} into the buffer; RESP->IDLE.
  - rvalid is never expected in the grant cycle; rvalid in IDLE is ignored. This covers a stale response after reset.
- Buffer:
  - FIFO; instr_valid = (count != 0); instr and instr_pc come from the head, registered storage.
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle: count unchanged, pointers both advance, wrap modulo BUF_DEPTH.
  - Push never overflows, because space is reserved at issue.
  - Latency: rvalid at cycle N gives instr_valid at N+1.
- Flush, effective in the same cycle:
  - imem_req and pc_advance are forced 0.
  - Next cycle: count=0, pointers reset, instr_valid=0. A pop in the flush cycle is ignored.
  - If state==RESP and no rvalid this cycle: set discard. The later rvalid is dropped, discard clears, RESP->IDLE.
  - If rvalid arrives in the flush cycle: data is dropped; RESP->IDLE.
  - Flush while discard is already set: no additional effect.
  - Flush in IDLE: only clears the buffer.
- Throughput: with gnt immediate and rvalid one cycle later, one instruction every 2 cycles.
- Invariant: count <= BUF_DEPTH; pc_advance never high while state==RESP.

Test Plan:
1. Reset, then pc_in=0x0000_0000, gnt=1, rvalid one cycle after gnt with rdata=0x0000_0013 -> imem_req=1 and pc_advance=1 in cycle 1; instr_valid=1 in cycle 3 with instr=0x13, instr_pc=0x0.
2. instr_ready=0, continuous responses -> exactly 2 instructions buffered (PCs 0x0, 0x4); imem_req stays 0 while full; ready=1 for one cycle -> one pop, one new request issued next cycle.
3. gnt held 0 for 3 cycles with pc_in=0x10 -> imem_req=1 and imem_addr=0x10 held stable, pc_advance=0 throughout; gnt=1 -> single pc_advance pulse.
4. Flush asserted in RESP before rvalid; later rvalid with rdata=0xDEAD_BEEF -> word dropped, instr_valid stays 0; next request uses redirected pc_in=0x100.
5. Flush coincident with rvalid, and with a buffer holding 2 entries -> buffer empty next cycle, response dropped, instr_valid=0.
6. rst asserted mid-RESP, stray rvalid after release -> ignored; outputs 0 until the first new grant.
